// File: rtl/seq_alu.sv
// seq_alu: multi-cycle accumulator ALU with registered N/Z/C/V flags.
// Single-cycle ops commit on the accept edge; shifts step one bit per cycle; MUL is a WIDTH-cycle shift-add.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] mdr,
  input  logic [WIDTH-1:0] value,
  output logic             ready,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] ac,
  output logic             nflg,
  output logic             zflg,
  output logic             cflg,
  output logic             vflg
);
  localparam int CW = SHW + 1;
  localparam logic [7:0] OP_LOAD = 8'h01, OP_LOADI = 8'h02, OP_ADD = 8'h05, OP_ADDI = 8'h06;
  localparam logic [7:0] OP_SUB  = 8'h07, OP_SUBI  = 8'h08, OP_NEG = 8'h09, OP_NOT  = 8'h0A;
  localparam logic [7:0] OP_AND  = 8'h0B, OP_OR    = 8'h0C, OP_XOR = 8'h0D, OP_SHL  = 8'h0E;
  localparam logic [7:0] OP_SHR  = 8'h0F, OP_ASR   = 8'h15, OP_MUL = 8'h16, OP_CMP  = 8'h17;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
  typedef enum logic [1:0] {SH_L, SH_R, SH_A} shdir_t;

  state_t             state, state_n;
  shdir_t             sh_dir, sh_dir_n;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand, mplr;
  logic               msign;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   opnd, res, sh_res, ac_abs, mdr_abs;
  logic [WIDTH:0]     add_ext, sub_ext, mul_sum;
  logic [2*WIDTH-1:0] prod_step, prod_fin;
  logic [SHW-1:0]     sh_cnt;
  logic               sh_c, c_res, v_res, wr_ac, wr_flg, commit, bad, sh_go, mul_go;

  assign ready     = (state == IDLE);
  assign opnd      = (opcode == OP_ADDI || opcode == OP_SUBI) ? value : mdr;
  assign add_ext   = {1'b0, ac} + {1'b0, opnd};
  assign sub_ext   = {1'b0, ac} - {1'b0, opnd};
  assign sh_cnt    = value[SHW-1:0];
  assign ac_abs    = ac[WIDTH-1] ? -ac : ac;
  assign mdr_abs   = mdr[WIDTH-1] ? -mdr : mdr;
  // Multiplier LSB-first: add at the top half, then shift the whole product right.
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
  assign prod_step = {mul_sum, prod[WIDTH-1:1]};
  assign prod_fin  = msign ? -prod_step : prod_step;

  always_comb begin
    sh_res = {ac[WIDTH-2:0], 1'b0};
    sh_c   = ac[WIDTH-1];
    if (sh_dir == SH_R) begin
      sh_res = {1'b0, ac[WIDTH-1:1]};
      sh_c   = ac[0];
    end else if (sh_dir == SH_A) begin
      sh_res = {ac[WIDTH-1], ac[WIDTH-1:1]};
      sh_c   = ac[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sh_dir_n = sh_dir;
    res      = ac;
    c_res    = cflg;
    v_res    = 1'b0;
    wr_ac    = 1'b0;
    wr_flg   = 1'b0;
    commit   = 1'b0;
    bad      = 1'b0;
    sh_go    = 1'b0;
    mul_go   = 1'b0;
    case (state)
      IDLE: if (start) begin
        commit = 1'b1;
        wr_ac  = 1'b1;
        wr_flg = 1'b1;
        case (opcode)
          OP_LOAD:  res = mdr;
          OP_LOADI: res = value;
          OP_ADD, OP_ADDI: begin
            res   = add_ext[WIDTH-1:0];
            c_res = add_ext[WIDTH];
            v_res = (ac[WIDTH-1] == opnd[WIDTH-1]) && (add_ext[WIDTH-1] != ac[WIDTH-1]);
          end
          OP_SUB, OP_SUBI, OP_CMP: begin
            res   = sub_ext[WIDTH-1:0];
            c_res = sub_ext[WIDTH];
            v_res = (ac[WIDTH-1] != opnd[WIDTH-1]) && (sub_ext[WIDTH-1] != ac[WIDTH-1]);
            wr_ac = (opcode != OP_CMP);
          end
          OP_NEG: begin
            res   = -mdr;
            v_res = (mdr == {1'b1, {(WIDTH-1){1'b0}}});
          end
          OP_NOT: res = ~mdr;
          OP_AND: res = ac & mdr;
          OP_OR:  res = ac | mdr;
          OP_XOR: res = ac ^ mdr;
          OP_SHL, OP_SHR, OP_ASR: if (sh_cnt != '0) begin
            commit   = 1'b0;
            wr_ac    = 1'b0;
            wr_flg   = 1'b0;
            sh_go    = 1'b1;
            state_n  = SHIFT;
            sh_dir_n = (opcode == OP_SHL) ? SH_L : (opcode == OP_SHR) ? SH_R : SH_A;
          end
          OP_MUL: begin
            commit  = 1'b0;
            wr_ac   = 1'b0;
            wr_flg  = 1'b0;
            mul_go  = 1'b1;
            state_n = MUL;
          end
          default: begin
            wr_ac  = 1'b0;
            wr_flg = 1'b0;
            bad    = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        res   = sh_res;
        c_res = sh_c;
        wr_ac = 1'b1;
        if (cnt == CW'(1)) begin
          wr_flg  = 1'b1;
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      MUL: if (cnt == CW'(1)) begin
        res     = prod_fin[WIDTH-1:0];
        v_res   = !((&prod_fin[2*WIDTH-1:WIDTH-1]) || (~|prod_fin[2*WIDTH-1:WIDTH-1]));
        wr_ac   = 1'b1;
        wr_flg  = 1'b1;
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ac      <= '0;
      nflg    <= 1'b0;
      zflg    <= 1'b1;
      cflg    <= 1'b0;
      vflg    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      cnt     <= '0;
      sh_dir  <= SH_L;
      mcand   <= '0;
      mplr    <= '0;
      msign   <= 1'b0;
      prod    <= '0;
    end else begin
      done    <= commit;
      illegal <= bad;
      sh_dir  <= sh_dir_n;
      if (wr_ac) ac <= res;
      if (wr_flg) begin
        nflg <= res[WIDTH-1];
        zflg <= (res == '0);
        cflg <= c_res;
        vflg <= v_res;
      end
      if (sh_go)             cnt <= CW'(sh_cnt);
      else if (mul_go)       cnt <= CW'(WIDTH);
      else if (state != IDLE) cnt <= cnt - CW'(1);
      if (mul_go) begin
        mcand <= ac_abs;
        mplr  <= mdr_abs;
        msign <= ac[WIDTH-1] ^ mdr[WIDTH-1];
        prod  <= '0;
      end else if (state == MUL) begin
        prod <= prod_step;
        mplr <= mplr >> 1;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a behavioural model pushes expected results at issue,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [7:0]   opcode = '0;
  logic [W-1:0] mdr = '0, value = '0;
  logic         ready, done, illegal, nflg, zflg, cflg, vflg;
  logic [W-1:0] ac;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .mdr(mdr), .value(value),
    .ready(ready), .done(done), .illegal(illegal), .ac(ac),
    .nflg(nflg), .zflg(zflg), .cflg(cflg), .vflg(vflg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ac;
    logic [3:0] nzcv;
    logic       ill;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         vectors = 0, miscompares = 0, done_cnt = 0;
  logic [7:0] m_ac;
  logic       m_n, m_z, m_c, m_v;
  logic [7:0] op_tbl [0:16] = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                                8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h15, 8'h16, 8'h17, 8'h04};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour written with plain integer arithmetic.
  task automatic model(input logic [7:0] op, input logic [7:0] md, input logic [7:0] va);
    exp_t              e;
    logic [7:0]        r, b;
    logic [8:0]        t;
    logic signed [7:0] sa8;
    int                s, p, n;
    logic              c, v, upd, wr;
    r = m_ac; c = m_c; v = 1'b0; upd = 1'b1; wr = 1'b1; e.ill = 1'b0;
    n = int'(va[2:0]);
    b = (op == 8'h06 || op == 8'h08) ? va : md;
    case (op)
      8'h01: r = md;
      8'h02: r = va;
      8'h05, 8'h06: begin
        t = {1'b0, m_ac} + {1'b0, b};
        r = t[7:0]; c = t[8];
        s = int'($signed(m_ac)) + int'($signed(b));
        v = (s > 127 || s < -128);
      end
      8'h07, 8'h08, 8'h17: begin
        r = m_ac - b; c = (m_ac < b);
        s = int'($signed(m_ac)) - int'($signed(b));
        v = (s > 127 || s < -128);
        wr = (op != 8'h17);
      end
      8'h09: begin r = 8'd0 - md; v = (md == 8'h80); end
      8'h0A: r = ~md;
      8'h0B: r = m_ac & md;
      8'h0C: r = m_ac | md;
      8'h0D: r = m_ac ^ md;
      8'h0E: if (n > 0) begin r = m_ac << n; c = m_ac[8-n]; end
      8'h0F: if (n > 0) begin r = m_ac >> n; c = m_ac[n-1]; end
      8'h15: if (n > 0) begin sa8 = m_ac; r = sa8 >>> n; c = m_ac[n-1]; end
      8'h16: begin
        p = int'($signed(m_ac)) * int'($signed(md));
        r = p[7:0];
        v = (p > 127 || p < -128);
      end
      default: begin upd = 1'b0; wr = 1'b0; e.ill = 1'b1; end
    endcase
    if (wr) m_ac = r;
    if (upd) begin m_n = r[7]; m_z = (r == 8'h00); m_c = c; m_v = v; end
    e.ac = m_ac;
    e.nzcv = {m_n, m_z, m_c, m_v};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] md, input logic [7:0] va);
    int t = 0;
    while (!ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!ready) chk("ready_timeout", 32'(ready), 32'(1));
    opcode = op; mdr = md; value = va; start = 1'b1;
    model(op, md, va);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (busy < 200) begin
      @(negedge clk);
      if (ready) break;
      busy++;
    end
    if (busy >= 200) chk("idle_timeout", 32'(ready), 32'(1));
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 32'(done), 32'(0));
      else begin
        mon_e = sb.pop_front();
        chk("sb_ac", 32'(ac), 32'(mon_e.ac));
        chk("sb_nzcv", 32'({nflg, zflg, cflg, vflg}), 32'(mon_e.nzcv));
        chk("sb_illegal", 32'(illegal), 32'(mon_e.ill));
      end
    end else if (illegal) chk("illegal_without_done", 32'(illegal), 32'(0));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, d0;
    m_ac = 8'h00; m_n = 1'b0; m_z = 1'b1; m_c = 1'b0; m_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    chk("rst_ac", 32'(ac), 32'h00);
    chk("rst_nzcv", 32'({nflg, zflg, cflg, vflg}), 32'b0100);
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_done_ill", 32'({done, illegal}), 32'(0));

    // Back-to-back single-cycle ops with overflow into the sign bit.
    d0 = done_cnt;
    issue(8'h02, 8'h00, 8'h7F);
    issue(8'h06, 8'h00, 8'h01);
    idle(1);
    chk("b2b_done", 32'(done_cnt - d0), 32'(2));
    chk("addi_ac", 32'(ac), 32'h80);
    chk("addi_nzcv", 32'({nflg, zflg, cflg, vflg}), 32'b1001);

    issue(8'h02, 8'h00, 8'h00);
    issue(8'h08, 8'h00, 8'h01);
    idle(1);
    chk("subi_ac", 32'(ac), 32'hFF);
    chk("subi_nzcv", 32'({nflg, zflg, cflg, vflg}), 32'b1010);
    issue(8'h17, 8'hFF, 8'h00);
    idle(1);
    chk("cmp_ac", 32'(ac), 32'hFF);
    chk("cmp_nzcv", 32'({nflg, zflg, cflg, vflg}), 32'b0100);

    // Shifts.
    issue(8'h02, 8'h00, 8'h81);
    idle(2);
    d0 = done_cnt;
    issue(8'h0F, 8'h00, 8'h03);
    wait_idle(busy);
    chk("shr_busy", 32'(busy), 32'(3));
    idle(2);
    chk("shr_ac", 32'(ac), 32'h10);
    chk("shr_c", 32'(cflg), 32'(0));
    chk("shr_done_once", 32'(done_cnt - d0), 32'(1));
    issue(8'h02, 8'h00, 8'h81);
    issue(8'h15, 8'h00, 8'h01);
    wait_idle(busy);
    chk("asr_busy", 32'(busy), 32'(1));
    chk("asr_ac", 32'(ac), 32'hC0);
    chk("asr_c", 32'(cflg), 32'(1));
    issue(8'h0E, 8'h00, 8'h00);
    idle(1);
    chk("shl0_ready", 32'(ready), 32'(1));
    chk("shl0_ac", 32'(ac), 32'hC0);
    chk("shl0_c", 32'(cflg), 32'(1));

    // MUL, with mdr changed right after acceptance.
    issue(8'h02, 8'h00, 8'hFD);
    issue(8'h16, 8'h05, 8'h00);
    mdr = 8'h77;
    wait_idle(busy);
    chk("mul_busy", 32'(busy), 32'(8));
    chk("mul_ac", 32'(ac), 32'hF1);
    chk("mul_nv", 32'({nflg, vflg}), 32'b10);

    // MUL overflow, with a start pulse during the busy window.
    issue(8'h02, 8'h00, 8'h40);
    idle(2);
    d0 = done_cnt;
    issue(8'h16, 8'h04, 8'h00);
    opcode = 8'h02; value = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(busy);
    idle(3);
    chk("mul_ovf_ac", 32'(ac), 32'h00);
    chk("mul_ovf_zv", 32'({zflg, vflg}), 32'b11);
    chk("busy_start_ignored", 32'(done_cnt - d0), 32'(1));

    // Unsupported opcode.
    issue(8'h04, 8'h12, 8'h34);
    @(negedge clk); #1;
    chk("ill_pulse", 32'({done, illegal}), 32'b11);
    @(negedge clk); #1;
    chk("ill_clear", 32'({done, illegal}), 32'b00);
    chk("ill_ac", 32'(ac), 32'(m_ac));

    // Reset in the third cycle of a MUL aborts it.
    issue(8'h02, 8'h00, 8'h05);
    idle(2);
    d0 = done_cnt;
    issue(8'h16, 8'h03, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    m_ac = 8'h00; m_n = 1'b0; m_z = 1'b1; m_c = 1'b0; m_v = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_ac", 32'(ac), 32'h00);
    chk("abort_nzcv", 32'({nflg, zflg, cflg, vflg}), 32'b0100);
    chk("abort_ready", 32'(ready), 32'(1));
    chk("abort_done", 32'({done, illegal}), 32'(0));
    issue(8'h02, 8'h00, 8'h3C);
    idle(1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'(1));
    chk("post_abort_ac", 32'(ac), 32'h3C);

    // Random mix through the scoreboard.
    for (int i = 0; i < 40; i++) begin
      issue(op_tbl[$urandom_range(16, 0)], 8'($urandom), 8'($urandom));
    end
    wait_idle(busy);
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
